// File: rtl/dual_rail_zero_counter_if.sv
// Dual-rail word bus into the zero counter and its registered result rails.
// The slave modport is the counter side; master is the producer/consumer side.
interface dual_rail_zero_counter_if #(
    parameter int WIDTH = 4,
    parameter int MOD   = 2
);
    localparam int CW = $clog2(MOD);

    logic [WIDTH-1:0] bit0;
    logic [WIDTH-1:0] bit1;
    logic             parity0;
    logic             parity1;
    logic [CW-1:0]    residue;
    logic             err;

    modport master (
        output bit0, bit1,
        input  parity0, parity1, residue, err
    );

    modport slave (
        input  bit0, bit1,
        output parity0, parity1, residue, err
    );
endinterface

// File: rtl/dual_rail_zero_counter.sv
// Counts zero-valued lanes of 4-phase dual-rail words modulo MOD, with dual-rail result.
// Define DRZC_INPUT_SYNC_EN to put a 2-flop synchroniser on every rail ahead of the sampler.
module dual_rail_zero_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dual_rail_zero_counter_if.slave bus
);
    localparam int CW = $clog2(MOD);
    localparam int ZW = $clog2(WIDTH + 1);
    localparam int SW = ((CW > ZW) ? CW : ZW) + 1;

    localparam logic [1:0] ST_RESYNC = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;

    logic [WIDTH-1:0] bit0_p0;
    logic [WIDTH-1:0] bit1_p0;
    logic             vld_p0;

    // Stage 0: input sampling (vld_p0 marks that the sample came from the pins, not from reset)
`ifdef DRZC_INPUT_SYNC_EN
    logic [WIDTH-1:0] bit0_s1, bit0_s2;
    logic [WIDTH-1:0] bit1_s1, bit1_s2;
    logic [1:0]       fill_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit0_s1 <= '0;
            bit0_s2 <= '0;
            bit1_s1 <= '0;
            bit1_s2 <= '0;
            bit0_p0 <= '0;
            bit1_p0 <= '0;
            fill_s  <= '0;
            vld_p0  <= 1'b0;
        end else begin
            bit0_s1 <= bus.bit0;
            bit0_s2 <= bit0_s1;
            bit1_s1 <= bus.bit1;
            bit1_s2 <= bit1_s1;
            bit0_p0 <= bit0_s2;
            bit1_p0 <= bit1_s2;
            fill_s  <= {fill_s[0], 1'b1};
            vld_p0  <= fill_s[1];
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit0_p0 <= '0;
            bit1_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            bit0_p0 <= bus.bit0;
            bit1_p0 <= bus.bit1;
            vld_p0  <= 1'b1;
        end
    end
`endif

    function automatic logic [ZW-1:0] count_zeros(input logic [WIDTH-1:0] b0,
                                                  input logic [WIDTH-1:0] b1);
        logic [ZW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + ZW'(b0[i] & ~b1[i]);
        end
        return n;
    endfunction

    // Sum is widened so the modulo sees the untruncated total.
    function automatic logic [CW-1:0] mod_add(input logic [CW-1:0] r,
                                              input logic [ZW-1:0] z);
        logic [SW-1:0] s;
        s = SW'(r) + SW'(z);
        return CW'(s % SW'(MOD));
    endfunction

    logic             word_full;
    logic             word_null;
    logic             word_ill;
    logic [ZW-1:0]    zeros_p0;
    logic [CW-1:0]    res_nxt;

    assign word_full = &(bit0_p0 ^ bit1_p0);
    assign word_null = ~|(bit0_p0 | bit1_p0);
    assign word_ill  = |(bit0_p0 & bit1_p0);
    assign zeros_p0  = count_zeros(bit0_p0, bit1_p0);

    logic [1:0]    state;
    logic          parity0_p1;
    logic          parity1_p1;
    logic [CW-1:0] residue_p1;
    logic          err_p1;

    assign res_nxt = mod_add(residue_p1, zeros_p0);

    // Stage 1: handshake FSM and accumulated result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RESYNC;
            parity0_p1 <= 1'b0;
            parity1_p1 <= 1'b0;
            residue_p1 <= '0;
            err_p1     <= 1'b0;
        end else begin
            if (word_ill) begin
                err_p1 <= 1'b1;
            end
            case (state)
                ST_RESYNC: begin
                    if (vld_p0 && word_null) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (word_full) begin
                        residue_p1 <= res_nxt;
                        parity0_p1 <= (res_nxt == '0);
                        parity1_p1 <= (res_nxt != '0);
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (word_null) begin
                        parity0_p1 <= 1'b0;
                        parity1_p1 <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    parity0_p1 <= 1'b0;
                    parity1_p1 <= 1'b0;
                    state      <= ST_RESYNC;
                end
            endcase
        end
    end

    assign bus.parity0 = parity0_p1;
    assign bus.parity1 = parity1_p1;
    assign bus.residue = residue_p1;
    assign bus.err     = err_p1;
endmodule
